aether_engine_cmd_fifo: RTL and testbench
=========================================

// Module: aether_engine_cmd_fifo
// PURPOSE
//  Command queue directly upstream of the aether engine decoder.
//  Buffers 24-bit host commands ({opcode[23:20], sub[19:16], payload[15:0]}) and presents
//  them to the decoder one per accepted handshake. Drives the decoder's buffer-full backpressure.
//  Presents NOP (24'h000000) on cmd_o whenever nothing is queued, so the decoder idles safely.
// PARAMETERS
//  Depth            16  entries; power of 2, >= 4
//  CmdWidth         24  command width in bits
//  AlmostFullMargin 2   almost_full_o asserts when count_o >= Depth - AlmostFullMargin
// PORTS
//  clk_i             in   1                     clock, all logic on rising edge
//  rst_i             in   1                     synchronous reset, active high
//  cmd_i             in   CmdWidth              command from host interface
//  cmd_valid_i       in   1                     cmd_i valid this cycle
//  full_o            out  1                     queue full; host must not push
//  almost_full_o     out  1                     early backpressure for pipelined hosts
//  cmd_o             out  CmdWidth              head command to decoder; NOP when cmd_valid_o=0
//  cmd_valid_o       out  1                     cmd_o holds a real queued command
//  cmd_ready_i       in   1                     decoder consumes cmd_o this cycle
//  count_o           out  $clog2(Depth)+1       entries currently queued
//  overflow_o        out  1                     sticky: a push was dropped while full
//  clear_overflow_i  in   1                     clears overflow_o
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): wr/rd pointers=0, count_o=0, full_o=0, almost_full_o=0,
//    cmd_valid_o=0, cmd_o=24'h0, overflow_o=0. Queued contents are discarded; reset wins
//    over any same-cycle push, pop or clear.
//  - Push: cmd_valid_i && !full_o && cmd_i[23:20]!=NOP -> write at wr_ptr, wr_ptr++ (mod Depth).
//  - NOP pushes are never enqueued and never count as overflow.
//  - Push while full_o=1: the command is dropped and overflow_o<=1. This applies even if a
//    pop occurs in the same cycle (full_o is a registered flag, no bypass).
//  - Pop: cmd_valid_o && cmd_ready_i -> rd_ptr++. cmd_ready_i with cmd_valid_o=0 is ignored.
//  - First-word fall-through with a registered head. A push into an empty queue gives
//    cmd_valid_o=1 on the next cycle (latency 1). No push->output bypass within a cycle.
//  - Back-to-back pops: one command per cycle while the queue is non-empty. After the pop of
//    the last entry, cmd_valid_o=0 and cmd_o=24'h0 on the next cycle.
//  - Simultaneous push and pop when 0<count<Depth: count is unchanged, both pointers advance.
//    Empty + push + ready: no pop occurs; count becomes 1.
//  - count_o, full_o and almost_full_o are registered and updated with next-state count.
//    full_o = (count==Depth).
//  - Pointers are $clog2(Depth) bits and wrap naturally. Full/empty is resolved by count,
//    not by a pointer MSB.
//  - overflow_o: set on a dropped push; cleared by clear_overflow_i. If both occur in the
//    same cycle, set wins.
//  - cmd_o is stable while cmd_valid_o=1 && cmd_ready_i=0.
// STRUCTURE
//  - aether_engine_pkg gets typedef enum logic [3:0] opcode_e: NOP=0, RESET=1, WRITE_REG=2,
//    READ_REG=3, START_TASK=4.
//  - aether_engine_pkg also gets typedef struct packed cmd_t {opcode_e op; logic [3:0] sub;
//    logic [15:0] payload;}. The decoder imports the same types.
//  - Storage is a flop array (Depth x CmdWidth) inline; no RAM macro at this depth.
//  - One sub-module: the existing d_ff holds the registered head (cmd_o/cmd_valid_o).
//  - Top level connects full_o to the decoder's buffer_full_o and cmd_o to its cmd_i.
// TESTING
//  1 Reset: push 3 cmds, assert rst_i one cycle -> next cycle count_o=0, cmd_valid_o=0,
//    cmd_o=24'h0, full_o=0.
//  2 Order and latency: push 24'h230042, 24'h3_70000, 24'h410000 with cmd_ready_i=1 ->
//    same order out, first cmd_valid_o one cycle after its push, then one per cycle.
//  3 Full/overflow: ready=0, push 17 non-NOP cmds (Depth=16) -> full_o=1 after 16;
//    almost_full_o at count 14; 17th dropped, overflow_o=1.
//  4 Full + push + pop in the same cycle -> push dropped, count_o=15, overflow_o=1;
//    clear_overflow_i with no drop -> overflow_o=0.
//  5 NOP filter: push 24'h000000 and 24'h0ABCDE -> count_o stays 0, overflow_o stays 0.
//  6 Wrap: 40 push/pop pairs with random ready stalls -> scoreboard match,
//    cmd_o stable during stalls.

Source files
------------

// File: rtl/aether_engine_cmd_fifo_pkg.sv
// Shared command types for the aether engine: the command queue and the decoder
// both import this so they agree on opcode encoding and command field layout.
package aether_engine_pkg;

    localparam int CMD_W = 24;

    typedef enum logic [3:0] {
        NOP        = 4'd0,
        RESET      = 4'd1,
        WRITE_REG  = 4'd2,
        READ_REG   = 4'd3,
        START_TASK = 4'd4
    } opcode_e;

    typedef struct packed {
        opcode_e     op;
        logic [3:0]  sub;
        logic [15:0] payload;
    } cmd_t;

    localparam cmd_t NOP_CMD = '0;

    // Opcode field of a raw command word
    function automatic opcode_e op_of(input logic [CMD_W-1:0] c);
        cmd_t tmp;
        tmp = cmd_t'(c);
        return tmp.op;
    endfunction

endpackage

// File: rtl/aether_engine_cmd_fifo_if.sv
// Host/decoder side signals of the command queue. The queue itself is the
// slave; whoever drives commands and consumes the head is the master.
interface aether_engine_cmd_fifo_if #(
    parameter int Depth    = 16,
    parameter int CmdWidth = 24
);
    localparam int CntW = $clog2(Depth) + 1;

    logic [CmdWidth-1:0] cmd_i;
    logic                cmd_valid_i;
    logic                full_o;
    logic                almost_full_o;
    logic [CmdWidth-1:0] cmd_o;
    logic                cmd_valid_o;
    logic                cmd_ready_i;
    logic [CntW-1:0]     count_o;
    logic                overflow_o;
    logic                clear_overflow_i;

    modport master (
        output cmd_i, cmd_valid_i, cmd_ready_i, clear_overflow_i,
        input  full_o, almost_full_o, cmd_o, cmd_valid_o, count_o, overflow_o
    );

    modport slave (
        input  cmd_i, cmd_valid_i, cmd_ready_i, clear_overflow_i,
        output full_o, almost_full_o, cmd_o, cmd_valid_o, count_o, overflow_o
    );

endinterface

// File: rtl/aether_engine_cmd_fifo_d_ff.sv
// Plain register with synchronous active-high clear to zero.
module aether_engine_cmd_fifo_d_ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Capture d every cycle; reset forces zero
    always_ff @(posedge clk_i) begin
        if (rst_i) q_o <= '0;
        else       q_o <= d_i;
    end

endmodule

// File: rtl/aether_engine_cmd_fifo.sv
// Command queue in front of the aether engine decoder. First-word fall-through
// with a registered head: the head register is loaded with whatever will be at
// the front after this edge, so cmd_o is a clean flop output and reads NOP
// whenever the queue is empty. full_o feeds the decoder's buffer_full_o and
// cmd_o feeds its cmd_i.
module aether_engine_cmd_fifo
    import aether_engine_pkg::*;
#(
    parameter int Depth            = 16,
    parameter int CmdWidth         = 24,
    parameter int AlmostFullMargin = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    aether_engine_cmd_fifo_if.slave bus
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [CmdWidth-1:0] mem [Depth];
    logic [PW-1:0]       wr_ptr, rd_ptr, rd_ptr_d;
    logic [CW-1:0]       count_q, count_after_pop, count_d;
    logic                full_q, af_q, ovf_q;
    logic                cmd_nop, push, pop, drop;
    logic [CmdWidth-1:0] head_d, head_q;
    logic                head_vld_d, head_vld_q;

    assign cmd_nop = (op_of(bus.cmd_i) == NOP);

    // Handshake decode and next-state count / head selection
    always_comb begin
        push            = bus.cmd_valid_i && !full_q && !cmd_nop;
        // full_q is registered, so a push against a full queue is dropped even
        // if the decoder frees a slot in the same cycle
        drop            = bus.cmd_valid_i && full_q && !cmd_nop;
        pop             = head_vld_q && bus.cmd_ready_i;
        count_after_pop = count_q - CW'(pop);
        count_d         = count_after_pop + CW'(push);
        rd_ptr_d        = rd_ptr + PW'(pop);
        head_vld_d      = (count_d != '0);
        head_d          = '0;
        if (count_after_pop != '0)
            head_d = mem[rd_ptr_d];
        else if (push)
            head_d = bus.cmd_i;   // incoming command becomes the new head
    end

    // Pointers, occupancy flags and the sticky overflow bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(Depth));
            af_q    <= (count_d >= CW'(Depth - AlmostFullMargin));
            if (drop)                      ovf_q <= 1'b1;
            else if (bus.clear_overflow_i) ovf_q <= 1'b0;
        end
    end

    // Entry storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem[wr_ptr] <= bus.cmd_i;
    end

    aether_engine_cmd_fifo_d_ff #(.W(CmdWidth + 1)) u_head (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({head_vld_d, head_d}),
        .q_o   ({head_vld_q, head_q})
    );

    assign bus.cmd_o         = head_q;
    assign bus.cmd_valid_o   = head_vld_q;
    assign bus.count_o       = count_q;
    assign bus.full_o        = full_q;
    assign bus.almost_full_o = af_q;
    assign bus.overflow_o    = ovf_q;

endmodule

// File: tb/tb_aether_engine_cmd_fifo.sv
// Bench for the aether engine command queue: directed scenarios plus random
// traffic, checked against a queue-based reference model and a scoreboard.
module tb_aether_engine_cmd_fifo;

    localparam int DEPTH = 16;
    localparam int AF_AT = DEPTH - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aether_engine_cmd_fifo_if #(.Depth(DEPTH), .CmdWidth(24)) bus ();

    aether_engine_cmd_fifo #(.Depth(DEPTH), .CmdWidth(24), .AlmostFullMargin(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          mcount = 0;
    bit          movf   = 1'b0;
    logic [23:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), advance the
    // reference model by the rules of the queue, then check the flags after the edge.
    task automatic cycle(input bit v, input logic [23:0] c, input bit rdy,
                         input bit clr, input bit r);
        bit nop, acc, drp, pp;
        bus.cmd_i            = c;
        bus.cmd_valid_i      = v;
        bus.cmd_ready_i      = rdy;
        bus.clear_overflow_i = clr;
        rst                  = r;
        if (r) begin
            mcount = 0;
            movf   = 1'b0;
            expq.delete();
        end else begin
            nop = (c[23:20] == 4'd0);
            acc = v && !nop && (mcount < DEPTH);
            drp = v && !nop && (mcount == DEPTH);
            pp  = rdy && (mcount > 0);
            if (acc) expq.push_back(c);
            mcount = mcount + int'(acc) - int'(pp);
            if (drp)      movf = 1'b1;
            else if (clr) movf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("count",       32'(bus.count_o),       mcount);
        chk("full",        32'(bus.full_o),        32'(mcount == DEPTH));
        chk("almost_full", 32'(bus.almost_full_o), 32'(mcount >= AF_AT));
        chk("overflow",    32'(bus.overflow_o),    32'(movf));
        chk("cmd_valid",   32'(bus.cmd_valid_o),   32'(mcount > 0));
        if (mcount == 0) chk("cmd_nop_idle", 32'(bus.cmd_o), 32'h0);
    endtask

    function automatic logic [23:0] rand_cmd(input bit allow_nop);
        logic [3:0] op;
        if (allow_nop && $urandom_range(0, 7) == 0) op = 4'd0;
        else op = 4'($urandom_range(1, 4));
        return {op, 20'($urandom)};
    endfunction

    // Scoreboard monitor: a handshake seen mid-cycle completes at the next edge
    logic        prev_stall = 1'b0;
    logic [23:0] prev_cmd   = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) chk("stable_during_stall", 32'(bus.cmd_o), 32'(prev_cmd));
            if (bus.cmd_valid_o && bus.cmd_ready_i) begin
                if (expq.size() == 0) chk("pop_with_empty_model", 32'(bus.cmd_valid_o), 32'h0);
                else                  chk("order", 32'(bus.cmd_o), 32'(expq.pop_front()));
            end
        end
        prev_stall = !rst && bus.cmd_valid_o && !bus.cmd_ready_i;
        prev_cmd   = bus.cmd_o;
    end

    initial begin
        bus.cmd_i            = '0;
        bus.cmd_valid_i      = 1'b0;
        bus.cmd_ready_i      = 1'b0;
        bus.clear_overflow_i = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 24'h0, 0, 0, 1);

        // Reset discards queued commands and wins over a same-cycle push
        for (int i = 0; i < 3; i++) cycle(1, rand_cmd(0), 0, 0, 0);
        cycle(1, 24'h211111, 1, 1, 1);
        cycle(0, 24'h0, 0, 0, 0);

        // Order and one-cycle latency with the decoder always ready
        cycle(1, 24'h230042, 1, 0, 0);
        cycle(1, 24'h370000, 1, 0, 0);
        cycle(1, 24'h410000, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 24'h0, 1, 0, 0);

        // Fill to full with the decoder stalled; the 17th push is dropped
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, rand_cmd(0), 0, 0, 0);
        chk("full_after_17", 32'(bus.full_o), 32'h1);
        chk("ovf_after_17",  32'(bus.overflow_o), 32'h1);

        // Push against full while popping: dropped, count drops to 15
        cycle(1, 24'h312345, 1, 0, 0);
        chk("count_full_push_pop", 32'(bus.count_o), 32'd15);
        cycle(0, 24'h0, 0, 1, 0);
        chk("ovf_cleared", 32'(bus.overflow_o), 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 24'h0, 1, 0, 0);

        // NOP pushes never enqueue and never count as overflow
        cycle(0, 24'h0, 0, 0, 1);
        cycle(1, 24'h000000, 0, 0, 0);
        cycle(1, 24'h0ABCDE, 1, 0, 0);
        chk("nop_count", 32'(bus.count_o), 32'h0);

        // Random traffic with ready stalls, wrapping the pointers many times
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, rand_cmd(1), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, 0);
        for (int i = 0; i < DEPTH + 4; i++) cycle(0, 24'h0, 1, 0, 0);
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
